// File: rtl/board_reset_ctrl_if.sv
// Board-side bundle for the reset sequencer: PLL lock and raw buttons in,
// SoC reset, ready flag, conditioned button events and reset cause out.
interface board_reset_ctrl_if #(
  parameter int NUM_BUTTONS = 1
);
  logic                   pll_locked;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   soc_rst_n;
  logic                   ready;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic [1:0]             reset_cause;

  modport master (
    output pll_locked, buttons,
    input  soc_rst_n, ready, btn_level, btn_press, btn_release, reset_cause
  );

  modport slave (
    input  pll_locked, buttons,
    output soc_rst_n, ready, btn_level, btn_press, btn_release, reset_cause
  );
endinterface

// File: rtl/board_reset_ctrl.sv
// Board reset sequencer: holds the SoC in reset until the PLL is locked and a
// stretch interval has passed; also debounces buttons and detects long presses.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_HOLD      | one-cycle reset hold after board reset or long press
// S_WAIT_LOCK | waiting for synchronised PLL lock
// S_STRETCH   | lock seen, counting stable-lock cycles before release
// S_RUN       | SoC released; watch for lock loss and long press
module board_reset_ctrl #(
  parameter int CLOCK_FREQ           = 100_000_000,
  parameter int NUM_BUTTONS          = 1,
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int RESET_STRETCH_CYCLES = 1024,
  parameter int LONG_PRESS_CYCLES    = 300_000_000,
  parameter int RESET_BUTTON_IDX     = 0
) (
  input  logic              clk,
  input  logic              rst,
  board_reset_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int ST_W = (RESET_STRETCH_CYCLES > 1) ? $clog2(RESET_STRETCH_CYCLES) : 1;
  localparam int LP_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(RESET_STRETCH_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES - 1);

  if (CLOCK_FREQ < 1 || NUM_BUTTONS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
      RESET_STRETCH_CYCLES < 1 || LONG_PRESS_CYCLES < 1 ||
      RESET_BUTTON_IDX < 0 || RESET_BUTTON_IDX >= NUM_BUTTONS) begin : g_bad_params
    $error("board_reset_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STRETCH,
    S_RUN
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [NUM_BUTTONS-1:0] btn_sync [SYNC_STAGES];
  logic                   lock_s;
  logic [NUM_BUTTONS-1:0] btn_s;
  logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] release_p;
  logic [ST_W-1:0]        st_cnt;
  logic [LP_W-1:0]        lp_cnt;
  logic                   armed;
  logic                   lp_fire;
  logic                   rb_level;
  logic [1:0]             cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) btn_sync[k] <= '0;
    end else begin
      lock_sync   <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
      btn_sync[0] <= bus.buttons;
      for (int k = 1; k < SYNC_STAGES; k++) btn_sync[k] <= btn_sync[k-1];
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign btn_s  = btn_sync[SYNC_STAGES-1];

  // Debounce runs in every state so levels are valid while the SoC is in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= '0;
      press     <= '0;
      release_p <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        press[i]     <= 1'b0;
        release_p[i] <= 1'b0;
        if (btn_s[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]     <= btn_s[i];
          db_cnt[i]    <= '0;
          press[i]     <= btn_s[i];
          release_p[i] <= ~btn_s[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rb_level = level[RESET_BUTTON_IDX];
  assign lp_fire  = (state == S_RUN) && rb_level && armed && (lp_cnt == LP_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_HOLD;
      st_cnt <= '0;
      lp_cnt <= '0;
      armed  <= 1'b1;
      cause  <= 2'd0;
    end else begin
      if (state != S_RUN || !rb_level) begin
        lp_cnt <= '0;
      end else if (armed) begin
        lp_cnt <= lp_fire ? '0 : lp_cnt + 1'b1;
      end

      // Re-arming needs a release, so a button held through reset fires once.
      if (!rb_level) begin
        armed <= 1'b1;
      end else if (lp_fire) begin
        armed <= 1'b0;
      end

      case (state)
        S_HOLD: begin
          state <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state  <= S_STRETCH;
            st_cnt <= '0;
          end
        end
        S_STRETCH: begin
          if (!lock_s) begin
            state  <= S_WAIT_LOCK;
            st_cnt <= '0;
          end else if (st_cnt == ST_MAX) begin
            state <= S_RUN;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            cause <= 2'd1;
          end else if (lp_fire) begin
            state <= S_HOLD;
            cause <= 2'd2;
          end
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

  assign bus.soc_rst_n   = (state == S_RUN);
  assign bus.ready       = (state == S_RUN);
  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = release_p;
  assign bus.reset_cause = cause;

endmodule
